// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-FF synchroniser, per-channel debounce FSM,
// registered level, press/release pulses and a one-shot long-press pulse.
module key_debounce_multi #(
  parameter int unsigned N_KEYS            = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 2000000,
  parameter int unsigned LONG_PRESS_CYCLES = 100000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int unsigned   DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned   HW   = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_t;

  state_t            r_state [N_KEYS];
  logic [DW-1:0]     r_dcnt  [N_KEYS];
  logic [HW-1:0]     r_hcnt  [N_KEYS];
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] r_long;

  logic [N_KEYS-1:0] w_p;
  logic [N_KEYS-1:0] w_hold;
  logic [N_KEYS-1:0] w_rel_done;
  logic [N_KEYS-1:0] w_long_hit;

  assign w_p = r_sync2 ^ {N_KEYS{ACTIVE_LOW}};

  // A release completing in the same cycle the hold count matures wins;
  // the long pulse is dropped so the three pulses stay mutually exclusive.
  always_comb begin
    w_hold     = '0;
    w_rel_done = '0;
    w_long_hit = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      w_hold[i]     = (r_state[i] == S_PRESSED) || (r_state[i] == S_RELEASE_WAIT);
      w_rel_done[i] = (r_state[i] == S_RELEASE_WAIT) && !w_p[i] && (r_dcnt[i] == DMAX);
      w_long_hit[i] = w_hold[i] && (r_hcnt[i] == HMAX - 1'b1) && !w_rel_done[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= {N_KEYS{ACTIVE_LOW}};
      r_sync2   <= {N_KEYS{ACTIVE_LOW}};
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        r_state[i] <= S_IDLE;
        r_dcnt[i]  <= '0;
        r_hcnt[i]  <= '0;
      end
    end else begin
      r_sync1   <= key_in;
      r_sync2   <= r_sync1;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= w_long_hit;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (w_hold[i] && (r_hcnt[i] != HMAX)) begin
          r_hcnt[i] <= r_hcnt[i] + 1'b1;
        end
        case (r_state[i])
          S_IDLE: begin
            if (w_p[i]) begin
              r_state[i] <= S_PRESS_WAIT;
              r_dcnt[i]  <= '0;
            end
          end
          S_PRESS_WAIT: begin
            if (!w_p[i]) begin
              r_state[i] <= S_IDLE;
              r_dcnt[i]  <= '0;
            end else if (r_dcnt[i] == DMAX) begin
              r_state[i] <= S_PRESSED;
              r_press[i] <= 1'b1;
              r_level[i] <= 1'b1;
              r_hcnt[i]  <= '0;
            end else begin
              r_dcnt[i] <= r_dcnt[i] + 1'b1;
            end
          end
          S_PRESSED: begin
            if (!w_p[i]) begin
              r_state[i] <= S_RELEASE_WAIT;
              r_dcnt[i]  <= '0;
            end
          end
          S_RELEASE_WAIT: begin
            if (w_p[i]) begin
              r_state[i] <= S_PRESSED;
            end else if (w_rel_done[i]) begin
              r_state[i]   <= S_IDLE;
              r_release[i] <= 1'b1;
              r_level[i]   <= 1'b0;
            end else begin
              r_dcnt[i] <= r_dcnt[i] + 1'b1;
            end
          end
          default: begin
            r_state[i] <= S_IDLE;
            r_dcnt[i]  <= '0;
          end
        endcase
      end
    end
  end

  assign key_state   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: table of level/pulse-count phases plus
// exact-latency sequences for bounce, long press, concurrency and reset.
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  key_debounce_multi #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(16),
    .LONG_PRESS_CYCLES(64),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          press_cnt [4] = '{default: 0};
  int          rel_cnt   [4] = '{default: 0};
  int          long_cnt  [4] = '{default: 0};
  int unsigned press_cyc [4] = '{default: 0};
  int unsigned rel_cyc   [4] = '{default: 0};
  int unsigned long_cyc  [4] = '{default: 0};
  int          excl_viol = 0;

  // Pulse recorder: each pulse is seen at exactly one falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[i] === 1'b1) begin
        press_cnt[i] <= press_cnt[i] + 1;
        press_cyc[i] <= cyc;
      end
      if (key_release[i] === 1'b1) begin
        rel_cnt[i] <= rel_cnt[i] + 1;
        rel_cyc[i] <= cyc;
      end
      if (key_long[i] === 1'b1) begin
        long_cnt[i] <= long_cnt[i] + 1;
        long_cyc[i] <= cyc;
      end
    end
    if (|((key_press & key_release) | (key_press & key_long) | (key_release & key_long)))
      excl_viol <= excl_viol + 1;
  end

  int checks = 0;
  int errors = 0;
  int b_press [4];
  int b_rel   [4];
  int b_long  [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      b_press[i] = press_cnt[i];
      b_rel[i]   = rel_cnt[i];
      b_long[i]  = long_cnt[i];
    end
  endtask

  // Per-channel pulse counts since the last snap(), one nibble per channel.
  function automatic logic [15:0] deltas(input int sel);
    logic [15:0] v;
    int d;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      case (sel)
        0:       d = press_cnt[i] - b_press[i];
        1:       d = rel_cnt[i] - b_rel[i];
        default: d = long_cnt[i] - b_long[i];
      endcase
      v[i*4 +: 4] = 4'(d);
    end
    return v;
  endfunction

  typedef struct {
    logic [3:0]  key;
    int unsigned hold;
    logic [3:0]  exp_state;
    logic [15:0] exp_press;
    logic [15:0] exp_rel;
    logic [15:0] exp_long;
  } vec_t;

  vec_t vt [9];

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned d;
    int unsigned target;

    vt[0] = '{4'hF, 100, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    vt[1] = '{4'hD,  10, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    vt[2] = '{4'hF,  40, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    vt[3] = '{4'hD,  40, 4'h2, 16'h0010, 16'h0000, 16'h0000};
    vt[4] = '{4'hF,  40, 4'h0, 16'h0000, 16'h0010, 16'h0000};
    vt[5] = '{4'h5,  40, 4'hA, 16'h1010, 16'h0000, 16'h0000};
    vt[6] = '{4'hF,  40, 4'h0, 16'h0000, 16'h1010, 16'h0000};
    vt[7] = '{4'h0, 100, 4'hF, 16'h1111, 16'h0000, 16'h1111};
    vt[8] = '{4'hF,  40, 4'h0, 16'h0000, 16'h1111, 16'h0000};

    rst_n  = 1'b0;
    key_in = 4'hF;
    tick(5);
    check("reset_outputs", {key_state, key_press, key_release, key_long}, 16'h0000);
    rst_n = 1'b1;
    tick(2);

    for (int r = 0; r < 9; r++) begin
      snap();
      key_in = vt[r].key;
      tick(vt[r].hold);
      check($sformatf("row%0d_state", r), key_state, vt[r].exp_state);
      check($sformatf("row%0d_press", r), deltas(0), vt[r].exp_press);
      check($sformatf("row%0d_release", r), deltas(1), vt[r].exp_rel);
      check($sformatf("row%0d_long", r), deltas(2), vt[r].exp_long);
    end

    // Bounced press on ch0: 10-cycle levels never satisfy the 16-cycle filter.
    snap();
    for (int k = 0; k < 20; k++) begin
      key_in[0] = (k % 2 == 1);
      tick(10);
    end
    check("bounce_no_press", deltas(0), 16'h0000);
    key_in[0] = 1'b0;
    d = cyc;
    tick(60);
    check("bounce_press_count", deltas(0), 16'h0001);
    check("bounce_press_time", press_cyc[0], d + 19);
    check("bounce_state", key_state, 4'h1);
    snap();
    key_in[0] = 1'b1;
    d = cyc;
    tick(40);
    check("bounce_release_time", rel_cyc[0], d + 19);
    check("bounce_release_count", deltas(1), 16'h0001);

    // Long press on ch2 then bounced release.
    snap();
    key_in = 4'hB;
    d = cyc;
    tick(300);
    check("long_press_count", deltas(0), 16'h0100);
    check("long_press_time", press_cyc[2], d + 19);
    check("long_count", deltas(2), 16'h0100);
    check("long_time", long_cyc[2], press_cyc[2] + 64);
    for (int k = 0; k < 5; k++) begin
      key_in = 4'hF;
      tick(8);
      key_in = 4'hB;
      tick(8);
    end
    check("long_bounce_state", key_state, 4'h4);
    key_in = 4'hF;
    d = cyc;
    tick(40);
    check("long_release_time", rel_cyc[2], d + 19);
    check("long_release_count", deltas(1), 16'h0100);
    check("long_once", deltas(2), 16'h0100);
    check("long_press_once", deltas(0), 16'h0100);
    check("long_state_after", key_state, 4'h0);

    // Concurrent presses on ch0/ch3 with a release on ch1.
    key_in = 4'hD;
    tick(40);
    snap();
    key_in = 4'h6;
    d = cyc;
    tick(40);
    check("conc_press0_time", press_cyc[0], d + 19);
    check("conc_press3_time", press_cyc[3], d + 19);
    check("conc_release1_time", rel_cyc[1], d + 19);
    check("conc_press_count", deltas(0), 16'h1001);
    check("conc_release_count", deltas(1), 16'h0010);
    check("conc_state", key_state, 4'h9);
    key_in = 4'hF;
    tick(40);

    // Reset while ch0 is filtering and ch3 is already accepted.
    key_in = 4'h7;
    tick(40);
    check("pre_reset_state", key_state, 4'h8);
    key_in = 4'h6;
    tick(8);
    snap();
    rst_n = 1'b0;
    tick(5);
    check("mid_reset_outputs", {key_state, key_press, key_release, key_long}, 16'h0000);
    check("mid_reset_no_pulse", deltas(0), 16'h0000);
    rst_n = 1'b1;
    d = cyc;
    tick(40);
    check("post_reset_press0_time", press_cyc[0], d + 19);
    check("post_reset_press3_time", press_cyc[3], d + 19);
    check("post_reset_press_count", deltas(0), 16'h1001);
    check("post_reset_release_count", deltas(1), 16'h0000);

    target = press_cyc[0] + 40;
    while (cyc < target) tick(1);
    snap();
    key_in = 4'h7;
    tick(150);
    check("suppress_release", deltas(1), 16'h0001);
    check("suppress_long0", long_cnt[0] - b_long[0], 0);
    key_in = 4'hF;
    tick(40);
    check("final_state", key_state, 4'h0);
    check("mutual_exclusion", excl_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Multi-channel, parametrised successor to the single-key debouncer. Each of N_KEYS mechanical key inputs is synchronised, debounced and converted into several outputs:
- a stable level;
- one-cycle press and release pulses;
- a one-shot long-press pulse.

Sits between board pins and user-interface control logic. Every channel is fully independent.

Parameters:
N_KEYS, 4, number of key channels (1..32)
DEBOUNCE_CYCLES, 2000000, consecutive stable cycles required to accept a level change (20 ms at 100 MHz); must be >= 2
LONG_PRESS_CYCLES, 100000000, cycles after accepted press before key_long fires (1 s at 100 MHz); must be >= 1
ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
key_in  input  N_KEYS  raw asynchronous key pins
key_state  output  N_KEYS  debounced level, 1 = pressed (polarity normalised)
key_press  output  N_KEYS  one-cycle pulse on accepted press
key_release  output  N_KEYS  one-cycle pulse on accepted release
key_long  output  N_KEYS  one-cycle pulse, once per press, after LONG_PRESS_CYCLES held

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low (rst_n, sampled on the rising edge of clk).
- Reset state, per channel:
  - 2-FF synchroniser loaded with the released level (1 if ACTIVE_LOW, else 0);
  - FSM in IDLE, all counters 0;
  - all outputs 0.
- Per-channel pipeline:
  - key_in → sync1 → sync2;
  - p = sync2 XOR ACTIVE_LOW, so p = 1 means pressed.
- Per-channel FSM, one debounce counter dcnt sized $clog2(DEBOUNCE_CYCLES):
  - IDLE: if p, go to PRESS_WAIT with dcnt = 0.
  - PRESS_WAIT:
    - if !p, go to IDLE with dcnt = 0;
    - else if dcnt == DEBOUNCE_CYCLES-1, go to PRESSED, key_press = 1 for one cycle, key_state = 1, hcnt = 0;
    - else dcnt++.
  - PRESSED: if !p, go to RELEASE_WAIT with dcnt = 0.
  - RELEASE_WAIT:
    - if p, go back to PRESSED (hcnt not cleared);
    - else if dcnt == DEBOUNCE_CYCLES-1, go to IDLE, key_release = 1 for one cycle, key_state = 0;
    - else dcnt++.
- Hold counter hcnt, sized $clog2(LONG_PRESS_CYCLES+1):
  - counts every cycle in PRESSED and RELEASE_WAIT, saturating at LONG_PRESS_CYCLES;
  - key_long pulses in the cycle hcnt transitions to LONG_PRESS_CYCLES, at most once per accepted press;
  - cleared on entry to PRESSED from PRESS_WAIT only.
- Latency: outputs are registered.
  - Raw edge first sampled at edge E0, input stable afterwards → key_press and key_state rise after edge E0+DEBOUNCE_CYCLES+2.
  - Release follows the same rule, with key_release and key_state falling.
- key_long: asserted LONG_PRESS_CYCLES cycles after the key_press cycle, provided no accepted release occurred in between.
- Bounce filtering: any return to the old level before the count completes restarts filtering. No pulse is emitted and key_state does not change.
- Mutual exclusion per channel: key_press, key_release and key_long are mutually exclusive in the same cycle. key_long may occur while a release is pending (RELEASE_WAIT).
- Channel independence: simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation: in-flight filtering and pending pulses are discarded with no pulse emitted. A key held through reset release is re-accepted DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- No combinational path exists from key_in to any output.

Test Plan:
All scenarios use N_KEYS=4, DEBOUNCE_CYCLES=16, LONG_PRESS_CYCLES=64, ACTIVE_LOW=1, 10 ns clock.
1. Reset → all outputs 0. key_in=4'hF for 100 cycles → no pulses, key_state=0.
2. Press bounce: key_in[0] toggles every 10 cycles for 20 toggles, then held 0 → exactly one key_press[0], 18 cycles after the first edge that samples the final 0; no pulses during bounce; key_state[0]=1.
3. Glitch: key_in[1]=0 for 10 cycles, then 1 → no key_press[1], key_state[1] stays 0; the counter restarts correctly on a later clean press.
4. Long press: key_in[2] held 0 for 300 cycles → key_press[2] once, then key_long[2] exactly 64 cycles later, then no further key_long. On release with 5 bounces of 8 cycles, key_release[2] fires once, 18 cycles after the final stable 1, and key_state[2] falls.
5. Concurrency: key_in[0] and key_in[3] pressed in the same cycle while key_in[1] is released → key_press[0] and key_press[3] assert in the same cycle; key_release[1] is independent and exact.
6. Reset mid-PRESS_WAIT with key_in[0] held 0 → no pulse during reset; key_press[0] exactly 18 cycles after rst_n rises. Also verify key_long suppression when released at hcnt=40.
